// File: rtl/pc_rx_frame_writer.sv
// rtl/pc_rx_frame_writer.sv - RX FIFO to frame-buffer writer; optional byte swap via PC_RX_FRAME_WRITER_BYTE_SWAP_EN
module pc_rx_frame_writer #(
  parameter int ADDR_WIDTH  = 12,
  parameter int FRAME_WORDS = 4096
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_fifo_empty,
  input  logic [31:0]           i_fifo_word,
  output logic                  o_fifo_read_cmd,
  input  logic [1:0]            i_packet_command,
  input  logic                  i_packet_fully_decoded,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_data,
  output logic                  o_mem_wr_en,
  input  logic                  i_mem_wr_ready,
  output logic                  o_frame_complete,
  output logic                  o_busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_data;
  logic                  r_restart_pending;
  logic                  r_frame_complete;

  logic                  w_cmd_restart;
  logic                  w_cmd_abort;
  logic                  w_last_word;
  logic [31:0]           w_latch_word;

  // Commands only count on the decoder strobe; ABORT also restarts the frame.
  assign w_cmd_restart = i_packet_fully_decoded && (i_packet_command == 2'b10);
  assign w_cmd_abort   = i_packet_fully_decoded && (i_packet_command == 2'b11);
  assign w_last_word   = (r_addr == LAST_ADDR);

`ifdef PC_RX_FRAME_WRITER_BYTE_SWAP_EN
  // PC sends little-end first; the frame buffer wants the opposite order.
  assign w_latch_word = {i_fifo_word[7:0], i_fifo_word[15:8],
                         i_fifo_word[23:16], i_fifo_word[31:24]};
`else
  assign w_latch_word = i_fifo_word;
`endif

  // Main sequencer: IDLE -> RD -> LATCH -> WRITE, with restart/abort handling.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state           <= S_IDLE;
      r_addr            <= '0;
      r_data            <= '0;
      r_restart_pending <= 1'b0;
      r_frame_complete  <= 1'b0;
    end else begin
      r_frame_complete <= 1'b0;

      // A new request always wins over the IDLE-cycle clear of the flag.
      if (w_cmd_restart || w_cmd_abort) begin
        r_restart_pending <= 1'b1;
      end else if ((r_state == S_IDLE) && r_restart_pending) begin
        r_restart_pending <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          // Restart is applied between words, costing one idle cycle.
          if (r_restart_pending) begin
            r_addr <= '0;
          end else if (!i_fifo_empty) begin
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_state <= S_LATCH;
        end
        S_LATCH: begin
          // FIFO data is valid one cycle after the read command.
          r_data  <= w_latch_word;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          if (w_cmd_abort) begin
            // Abort beats a same-cycle accept: the write never happened.
            r_state <= S_IDLE;
          end else if (i_mem_wr_ready) begin
            if (w_last_word) begin
              r_addr           <= '0;
              r_frame_complete <= 1'b1;
            end else begin
              r_addr <= r_addr + ONE_ADDR;
            end
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_fifo_read_cmd  = (r_state == S_RD);
  assign o_mem_wr_en      = (r_state == S_WRITE);
  assign o_mem_addr       = r_addr;
  assign o_mem_data       = r_data;
  assign o_frame_complete = r_frame_complete;
  assign o_busy           = (r_state != S_IDLE);

endmodule

// File: tb/tb_pc_rx_frame_writer.sv
// tb/tb_pc_rx_frame_writer.sv - scoreboard bench for pc_rx_frame_writer
module tb_pc_rx_frame_writer;

  localparam int AW = 3;
  localparam int FW = 7;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_fifo_empty;
  logic [31:0]   i_fifo_word;
  logic          o_fifo_read_cmd;
  logic [1:0]    i_packet_command;
  logic          i_packet_fully_decoded;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_data;
  logic          o_mem_wr_en;
  logic          i_mem_wr_ready;
  logic          o_frame_complete;
  logic          o_busy;

  always #5 clk = ~clk;

  pc_rx_frame_writer #(.ADDR_WIDTH(AW), .FRAME_WORDS(FW)) dut (
    .i_clock                (clk),
    .i_reset                (i_reset),
    .i_fifo_empty           (i_fifo_empty),
    .i_fifo_word            (i_fifo_word),
    .o_fifo_read_cmd        (o_fifo_read_cmd),
    .i_packet_command       (i_packet_command),
    .i_packet_fully_decoded (i_packet_fully_decoded),
    .o_mem_addr             (o_mem_addr),
    .o_mem_data             (o_mem_data),
    .o_mem_wr_en            (o_mem_wr_en),
    .i_mem_wr_ready         (i_mem_wr_ready),
    .o_frame_complete       (o_frame_complete),
    .o_busy                 (o_busy)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    bit            last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          model_addr = 0;
  bit          rand_ready = 1'b0;
  bit          cmd_drive = 1'b0;
  bit          rd_prev = 1'b0;

  function automatic logic [31:0] frame_order(input logic [31:0] w);
`ifdef PC_RX_FRAME_WRITER_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sequential word index modulo FW, zeroed by restart/abort/reset.
  task automatic expect_write(input logic [31:0] w);
    exp_t e;
    e.addr = AW'(model_addr);
    e.data = frame_order(w);
    e.last = (model_addr == FW - 1);
    exp_q.push_back(e);
    model_addr = (model_addr + 1) % FW;
  endtask

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    i_fifo_empty = 1'b0;
  endtask

  task automatic wait_quiet();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !o_busy) begin
        done = 1'b1;
        break;
      end
    end
    check("quiet_reached", done, 1);
  endtask

  task automatic plain_word(input logic [31:0] w);
    expect_write(w);
    push_word(w);
  endtask

  task automatic align_to(input int a);
    rand_ready = 1'b0;
    i_mem_wr_ready = 1'b1;
    while (model_addr != a) plain_word($urandom);
    wait_quiet();
  endtask

  task automatic cmd_word(input logic [31:0] w, input logic [1:0] cmd, input int stall, input logic rdy);
    bit seen;
    wait_quiet();
    rand_ready = 1'b0;
    i_mem_wr_ready = 1'b0;
    if (cmd == 2'b11) begin
      model_addr = 0;
    end else begin
      expect_write(w);
      if (cmd == 2'b10) model_addr = 0;
    end
    push_word(w);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (o_mem_wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    check("cmd_write_seen", seen, 1);
    repeat (stall) begin
      @(negedge clk); #1;
    end
    cmd_drive = 1'b1;
    i_packet_command = cmd;
    i_packet_fully_decoded = 1'b1;
    i_mem_wr_ready = rdy;
    @(negedge clk); #1;
    i_packet_fully_decoded = 1'b0;
    cmd_drive = 1'b0;
    i_mem_wr_ready = 1'b1;
    if (cmd == 2'b11) check("abort_wr_en_drop", o_mem_wr_en, 0);
    wait_quiet();
  endtask

  // FIFO model: data valid only in the cycle after a read; random noise otherwise.
  always @(negedge clk) begin
    if (rd_prev) begin
      check("fifo_nonempty_on_read", fifo_q.size() != 0, 1);
      if (fifo_q.size() != 0) i_fifo_word = fifo_q.pop_front();
      else i_fifo_word = $urandom;
    end else begin
      i_fifo_word = $urandom;
    end
    rd_prev = o_fifo_read_cmd;
    i_fifo_empty = (fifo_q.size() == 0);
    if (rand_ready) i_mem_wr_ready = 1'($urandom_range(0, 1));
    if (!cmd_drive) i_packet_command = 2'($urandom);
  end

  // Monitor: pops the scoreboard on each accepted write.
  bit            fc_check = 1'b0;
  bit            fc_exp = 1'b0;
  bit            prev_hold = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_data = '0;
  always @(negedge clk) begin
    bit   abort_now;
    bit   acc;
    exp_t e;
    #3;
    abort_now = i_packet_fully_decoded && (i_packet_command == 2'b11);
    acc = !i_reset && o_mem_wr_en && i_mem_wr_ready && !abort_now;
    if (fc_check) begin
      check("frame_complete", o_frame_complete, fc_exp);
      fc_check = 1'b0;
    end else begin
      check("no_frame_complete", o_frame_complete, 0);
    end
    if (prev_hold) check("write_held", {o_mem_wr_en, o_mem_addr, o_mem_data}, {1'b1, prev_addr, prev_data});
    if (acc) begin
      check("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("write_addr", o_mem_addr, e.addr);
        check("write_data", o_mem_data, e.data);
        fc_check = 1'b1;
        fc_exp = e.last;
      end
    end
    prev_hold = o_mem_wr_en && !acc && !abort_now && !i_reset;
    prev_addr = o_mem_addr;
    prev_data = o_mem_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k_rd;
    int k_wr;
    int r;
    i_reset = 1'b1;
    i_fifo_empty = 1'b1;
    i_fifo_word = '0;
    i_packet_command = 2'b00;
    i_packet_fully_decoded = 1'b0;
    i_mem_wr_ready = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("idle_outputs", {o_fifo_read_cmd, o_mem_wr_en, o_busy, o_frame_complete, o_mem_addr}, 0);
    end

    i_mem_wr_ready = 1'b1;
    plain_word(32'hDEADBEEF);
    k_rd = 0;
    k_wr = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (o_fifo_read_cmd && k_rd == 0) k_rd = k;
      if (o_mem_wr_en) begin
        k_wr = k;
        break;
      end
    end
    check("read_latency", k_rd, 1);
    check("write_latency", k_wr, 3);
    wait_quiet();
    plain_word(32'h0BADF00D);
    wait_quiet();

    i_mem_wr_ready = 1'b0;
    plain_word(32'h12345678);
    plain_word(32'hCAFEF00D);
    k_wr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (o_mem_wr_en) begin
        k_wr = 1;
        break;
      end
    end
    check("stall_write_seen", k_wr, 1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        @(negedge clk); #1;
      end
      check("stall_wr_en_held", o_mem_wr_en, 1);
      check("stall_no_read", o_fifo_read_cmd, 0);
    end
    @(negedge clk);
    i_mem_wr_ready = 1'b1;
    wait_quiet();

    for (int i = 0; i < FW + 1; i++) plain_word($urandom);
    wait_quiet();

    align_to(5);
    cmd_word(32'hA5A50005, 2'b10, 2, 1'b0);
    plain_word(32'h00C0FFEE);
    wait_quiet();

    align_to(FW - 1);
    cmd_word(32'h1A571A57, 2'b10, 0, 1'b1);
    plain_word(32'h0000F1F0);
    wait_quiet();

    align_to(3);
    cmd_word(32'hAB0A7000, 2'b11, 2, 1'b0);
    plain_word(32'hAB0A7001);
    wait_quiet();

    align_to(FW - 1);
    cmd_word(32'hAB0A7002, 2'b11, 1, 1'b1);
    plain_word(32'hAB0A7003);
    wait_quiet();

    cmd_word(32'h5EED0000, 2'b00, 1, 1'b1);
    cmd_word(32'h5EED0001, 2'b01, 0, 1'b1);

    align_to(4);
    rand_ready = 1'b0;
    i_mem_wr_ready = 1'b1;
    push_word(32'hDEAD0001);
    @(negedge clk); #1;
    check("rst_test_read_cmd", o_fifo_read_cmd, 1);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk); #1;
    check("reset_in_latch_outputs",
          {o_fifo_read_cmd, o_mem_wr_en, o_busy, o_frame_complete, o_mem_addr, o_mem_data}, 0);
    i_reset = 1'b0;
    model_addr = 0;
    plain_word(32'h600DF00D);
    wait_quiet();

    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        rand_ready = 1'($urandom_range(0, 1));
        if (!rand_ready) i_mem_wr_ready = 1'b1;
        for (int n = $urandom_range(1, 4); n > 0; n--) begin
          plain_word($urandom);
          repeat ($urandom_range(0, 5)) @(negedge clk);
        end
      end else if (r < 9) begin
        cmd_word($urandom, 2'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end else begin
        wait_quiet();
      end
    end
    rand_ready = 1'b0;
    i_mem_wr_ready = 1'b1;
    wait_quiet();
    check("scoreboard_drained", exp_q.size(), 0);
    check("fifo_drained", fifo_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
